// File: rtl/router_pkg.sv
// Shared types and constants for the router reset sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package router_pkg;

  localparam int N_PORTS = 4;

  typedef enum logic [1:0] {
    RSQ_HOLD,
    RSQ_INIT,
    RSQ_PORTS,
    RSQ_READY
  } rst_seq_state_t;

  // Largest of three cycle limits, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable saturating up-counter with clear, enable and terminal-count flag.
// Latency: count visible the cycle after clear/load/enable; o_tc is combinational on the count.
// Backpressure: none; holds at i_term until cleared or loaded.
module rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_srst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Count up to the terminal value and hold there; clear has priority over load.
  always_ff @(posedge i_clk) begin
    if (i_srst || i_clr) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_en && (r_cnt < i_term)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/router_rst_sequencer.sv
// Staged reset release: hold all, release core, handshake table init, release ports one by one.
// Latency: HOLD_CYCLES + init wait + (N_PORTS-1)*STAGGER cycles from reset release to ready.
// Backpressure: waits on init_ack up to INIT_TIMEOUT cycles; sw_rst_req restarts at any time.
module router_rst_sequencer #(
  parameter int N_PORTS      = router_pkg::N_PORTS,
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGGER      = 4,
  parameter int INIT_TIMEOUT = 1024
) (
  input  logic               CLK,
  input  logic               SRST,
  input  logic               sw_rst_req,
  input  logic               init_ack,
  output logic               core_srst,
  output logic [N_PORTS-1:0] port_srst,
  output logic               init_req,
  output logic               ready,
  output logic               init_err
);

  import router_pkg::*;

  localparam int CW = $clog2(max3(HOLD_CYCLES, STAGGER, INIT_TIMEOUT) + 1);

  rst_seq_state_t     r_state, w_nxt_state;
  logic               r_core, w_nxt_core;
  logic [N_PORTS-1:0] r_port, w_nxt_port;
  logic               r_req, w_nxt_req;
  logic               r_ready, w_nxt_ready;
  logic               r_err, w_nxt_err;
  logic               w_clr;
  logic               w_tc;
  logic [CW-1:0]      w_term;
  logic [N_PORTS-1:0] w_port_shift;
  logic               w_last;

  // Releasing a port clears the next-lowest bit still in reset.
  assign w_port_shift = r_port << 1;
  assign w_last       = (w_port_shift == '0);

  // Terminal count for the state being timed; the timer restarts on each state change.
  always_comb begin
    w_term = CW'(STAGGER - 1);
    case (r_state)
      RSQ_HOLD: w_term = CW'(HOLD_CYCLES - 1);
      RSQ_INIT: w_term = CW'(INIT_TIMEOUT - 1);
      default:  w_term = CW'(STAGGER - 1);
    endcase
  end

  rst_seq_timer #(.W(CW)) u_timer (
    .i_clk    (CLK),
    .i_srst   (SRST),
    .i_clr    (w_clr),
    .i_en     (1'b1),
    .i_ld     (1'b0),
    .i_ld_val ({CW{1'b0}}),
    .i_term   (w_term),
    .o_tc     (w_tc)
  );

  // Next state and next registered outputs; software reset overrides every state.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_core  = r_core;
    w_nxt_port  = r_port;
    w_nxt_req   = r_req;
    w_nxt_ready = r_ready;
    w_nxt_err   = r_err;
    w_clr       = 1'b0;
    if (sw_rst_req) begin
      w_nxt_state = RSQ_HOLD;
      w_nxt_core  = 1'b1;
      w_nxt_port  = '1;
      w_nxt_req   = 1'b0;
      w_nxt_ready = 1'b0;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        RSQ_HOLD: begin
          if (w_tc) begin
            w_nxt_state = RSQ_INIT;
            w_nxt_core  = 1'b0;
            w_nxt_req   = 1'b1;
            w_clr       = 1'b1;
          end
        end
        RSQ_INIT: begin
          // An ack on the timeout cycle still counts as a clean init.
          if (init_ack || w_tc) begin
            w_nxt_req   = 1'b0;
            w_nxt_err   = r_err | ~init_ack;
            w_nxt_port  = w_port_shift;
            w_nxt_state = w_last ? RSQ_READY : RSQ_PORTS;
            w_nxt_ready = w_last;
            w_clr       = 1'b1;
          end
        end
        RSQ_PORTS: begin
          if (w_tc) begin
            w_nxt_port  = w_port_shift;
            w_nxt_state = w_last ? RSQ_READY : RSQ_PORTS;
            w_nxt_ready = w_last;
            w_clr       = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers; SRST forces the full reset pattern and clears the error flag.
  always_ff @(posedge CLK) begin
    if (SRST) begin
      r_state <= RSQ_HOLD;
      r_core  <= 1'b1;
      r_port  <= '1;
      r_req   <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_core  <= w_nxt_core;
      r_port  <= w_nxt_port;
      r_req   <= w_nxt_req;
      r_ready <= w_nxt_ready;
      r_err   <= w_nxt_err;
    end
  end

  assign core_srst = r_core;
  assign port_srst = r_port;
  assign init_req  = r_req;
  assign ready     = r_ready;
  assign init_err  = r_err;

endmodule

// File: tb/tb_router_rst_sequencer.sv
// Self-checking bench for router_rst_sequencer with a timeline reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_router_rst_sequencer;

  localparam int H  = 16;
  localparam int S  = 4;
  localparam int N  = 4;
  localparam int T  = 1024;
  localparam int H6 = 1;
  localparam int S6 = 1;
  localparam int N6 = 1;
  localparam int T6 = 8;

  logic       clk;
  logic       srst, sw, ack;
  logic       core, req, rdy, err;
  logic [3:0] port;
  logic       srst6, sw6, ack6;
  logic       core6, req6, rdy6, err6;
  logic [0:0] port6;
  logic [7:0] obs4, obs6;

  int n_chk = 0;
  int n_bad = 0;

  router_rst_sequencer #(
    .N_PORTS(N), .HOLD_CYCLES(H), .STAGGER(S), .INIT_TIMEOUT(T)
  ) dut (
    .CLK(clk), .SRST(srst), .sw_rst_req(sw), .init_ack(ack),
    .core_srst(core), .port_srst(port), .init_req(req), .ready(rdy), .init_err(err)
  );

  router_rst_sequencer #(
    .N_PORTS(N6), .HOLD_CYCLES(H6), .STAGGER(S6), .INIT_TIMEOUT(T6)
  ) dut6 (
    .CLK(clk), .SRST(srst6), .sw_rst_req(sw6), .init_ack(ack6),
    .core_srst(core6), .port_srst(port6), .init_req(req6), .ready(rdy6), .init_err(err6)
  );

  assign obs4 = {core, req, rdy, err, port};
  assign obs6 = {core6, req6, rdy6, err6, 3'b000, port6};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {core_srst, init_req, ready, init_err, port_srst[3:0]} at cycle t after a restart.
  // t=0 is the first cycle showing the restarted hold; w is the number of init cycles
  // including the one on which ack is sampled (or the timeout length).
  function automatic logic [7:0] model(input int t, input int h, input int s, input int n,
                                       input int w, input bit tmo, input bit err_in);
    logic [7:0] v;
    v = '0;
    v[7] = (t < h);
    v[6] = (t >= h) && (t < h + w);
    v[5] = (t >= h + w + (n - 1) * s);
    v[4] = err_in || (tmo && (t >= h + w));
    for (int k = 0; k < n; k++) v[k] = (t < h + w + k * s);
    return v;
  endfunction

  // Ack to drive for sampling at the end of cycle t.
  function automatic bit ack_drive(input int t, input int h, input int w, input bit level,
                                   input bit noise, input bit no_ack);
    if (t <= h - 1) return noise;
    if (no_ack) return 1'b0;
    return level ? (t >= h + w - 1) : (t == h + w - 1);
  endfunction

  task automatic test_reset;
    srst = 1'b1; sw = 1'b0; ack = 1'b0;
    srst6 = 1'b1; sw6 = 1'b0; ack6 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (obs4 !== 8'b1000_1111) begin
        n_bad++;
        $display("FAIL reset4 got=%b want=%b", obs4, 8'b1000_1111);
      end
      n_chk++;
      if (obs6 !== 8'b1000_0001) begin
        n_bad++;
        $display("FAIL reset6 got=%b want=%b", obs6, 8'b1000_0001);
      end
    end
  endtask

  // Default release with ack sampled on the 5th init cycle.
  task automatic test_first_release;
    logic [7:0] e;
    int w;
    w = 5;
    srst = 1'b0;
    for (int t = 0; t <= H + w + (N - 1) * S + 3; t++) begin
      e = model(t, H, S, N, w, 1'b0, 1'b0);
      n_chk++;
      if (obs4 !== e) begin
        n_bad++;
        $display("FAIL first_release t=%0d got=%b want=%b", t, obs4, e);
      end
      ack = ack_drive(t, H, w, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    ack = 1'b0;
  endtask

  // Software restart pulses from READY with random ack timing, style and hold-phase noise.
  task automatic test_random_restart;
    logic [7:0] e;
    int w;
    bit level, noisy;
    for (int it = 0; it < 5; it++) begin
      w = $urandom_range(1, 12);
      level = 1'($urandom_range(0, 1));
      noisy = 1'($urandom_range(0, 1));
      sw = 1'b1;
      @(posedge clk); #1;
      sw = 1'b0;
      for (int t = 0; t <= H + w + (N - 1) * S + 3; t++) begin
        e = model(t, H, S, N, w, 1'b0, 1'b0);
        n_chk++;
        if (obs4 !== e) begin
          n_bad++;
          $display("FAIL restart it=%0d w=%0d t=%0d got=%b want=%b", it, w, t, obs4, e);
        end
        ack = ack_drive(t, H, w, level, noisy && ($urandom_range(0, 1) == 1), 1'b0);
        @(posedge clk); #1;
      end
      ack = 1'b0;
    end
  endtask

  // Run 0: no ack ever, error flagged after the timeout. Run 1: software restart keeps the error.
  task automatic test_timeout;
    logic [7:0] e;
    int w;
    bit tmo, errp;
    for (int run = 0; run < 2; run++) begin
      if (run == 0) begin
        w = T; tmo = 1'b1; errp = 1'b0;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
      end else begin
        w = 3; tmo = 1'b0; errp = 1'b1;
        sw = 1'b1;
        @(posedge clk); #1;
        sw = 1'b0;
      end
      for (int t = 0; t <= H + w + (N - 1) * S + 2; t++) begin
        e = model(t, H, S, N, w, tmo, errp);
        n_chk++;
        if (obs4 !== e) begin
          n_bad++;
          $display("FAIL timeout run=%0d t=%0d got=%b want=%b", run, t, obs4, e);
        end
        ack = ack_drive(t, H, w, 1'b0, 1'b0, tmo);
        @(posedge clk); #1;
      end
      ack = 1'b0;
    end
  endtask

  // Ack exactly on the timeout cycle, with ack held high through the whole hold phase.
  task automatic test_ack_on_timeout;
    logic [7:0] e;
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    for (int t = 0; t <= H + T + (N - 1) * S + 2; t++) begin
      e = model(t, H, S, N, T, 1'b0, 1'b0);
      n_chk++;
      if (obs4 !== e) begin
        n_bad++;
        $display("FAIL ack_on_timeout t=%0d got=%b want=%b", t, obs4, e);
      end
      ack = ack_drive(t, H, T, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    ack = 1'b0;
  endtask

  // SRST pulse while ports read 1100, then a full replay.
  task automatic test_srst_mid;
    logic [7:0] e;
    int w, tstop;
    w = 4;
    tstop = H + w + S;
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    for (int t = 0; t <= tstop; t++) begin
      e = model(t, H, S, N, w, 1'b0, 1'b0);
      n_chk++;
      if (obs4 !== e) begin
        n_bad++;
        $display("FAIL srst_mid t=%0d got=%b want=%b", t, obs4, e);
      end
      if (t == tstop) begin
        ack = 1'b0;
        srst = 1'b1;
      end else begin
        ack = ack_drive(t, H, w, 1'b0, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
    end
    srst = 1'b0;
    w = $urandom_range(1, 8);
    for (int t = 0; t <= H + w + (N - 1) * S + 2; t++) begin
      e = model(t, H, S, N, w, 1'b0, 1'b0);
      n_chk++;
      if (obs4 !== e) begin
        n_bad++;
        $display("FAIL srst_replay t=%0d got=%b want=%b", t, obs4, e);
      end
      ack = ack_drive(t, H, w, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    ack = 1'b0;
  endtask

  // Single-port, minimal-timing instance: held software reset, then release and timeout.
  task automatic test_small;
    logic [7:0] e;
    int w;
    bit tmo;
    srst6 = 1'b0;
    sw6 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      e = model(0, H6, S6, N6, 1, 1'b0, 1'b0);
      n_chk++;
      if (obs6 !== e) begin
        n_bad++;
        $display("FAIL small_hold i=%0d got=%b want=%b", i, obs6, e);
      end
    end
    sw6 = 1'b0;
    for (int run = 0; run < 2; run++) begin
      if (run == 0) begin
        w = $urandom_range(1, 5); tmo = 1'b0;
      end else begin
        w = T6; tmo = 1'b1;
        sw6 = 1'b1;
        @(posedge clk); #1;
        sw6 = 1'b0;
      end
      for (int t = 0; t <= H6 + w + 3; t++) begin
        e = model(t, H6, S6, N6, w, tmo, 1'b0);
        n_chk++;
        if (obs6 !== e) begin
          n_bad++;
          $display("FAIL small run=%0d w=%0d t=%0d got=%b want=%b", run, w, t, obs6, e);
        end
        ack6 = ack_drive(t, H6, w, 1'b0, 1'b0, tmo);
        @(posedge clk); #1;
      end
      ack6 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_first_release();
    test_random_restart();
    test_timeout();
    test_ack_on_timeout();
    test_srst_mid();
    test_small();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
